// File: rtl/hazard_forward_unit_pkg.sv
// Shared pipeline constants for the hazard/forwarding logic and the stage
// modules that consume its operand-select encoding.
package hazard_forward_unit_pkg;

    // Default register-file address width of the 5-stage pipeline.
    localparam int ADDR_W = 5;

    // EX operand mux select encoding.
    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REG   = 2'b00;  // value read from the register file
    localparam fwd_sel_t FWD_EXMEM = 2'b01;  // ALU result held in EX/MEM
    localparam fwd_sel_t FWD_MEMWB = 2'b10;  // write-back value held in MEM/WB

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Bundle of the signals exchanged between the pipeline datapath and the
// hazard/forwarding controller. The datapath side is the master.
interface hazard_forward_unit_if #(
    parameter int ADDR_W = hazard_forward_unit_pkg::ADDR_W,
    parameter int CNT_W  = 16
);
    import hazard_forward_unit_pkg::*;

    // ID-stage source fields
    logic [ADDR_W-1:0] ID_RSAddr;
    logic [ADDR_W-1:0] ID_RTAddr;
    logic              ID_UsesRS;
    logic              ID_UsesRT;

    // ID/EX register outputs for the instruction currently in EX
    logic              EX_RegWrite;
    logic              EX_Mem2Reg;
    logic              EX_RegDst;
    logic [ADDR_W-1:0] EX_RSAddr;
    logic [ADDR_W-1:0] EX_RTAddr;
    logic [ADDR_W-1:0] EX_RDAddr;
    logic              EX_BranchTaken;

    // Controller decisions
    logic              Stall;
    logic              Flush_IFID;
    logic              Flush_IDEX;
    fwd_sel_t          FwdA_Sel;
    fwd_sel_t          FwdB_Sel;
    logic [CNT_W-1:0]  StallCount;
    logic [CNT_W-1:0]  FlushCount;

    modport master (
        output ID_RSAddr, ID_RTAddr, ID_UsesRS, ID_UsesRT,
        output EX_RegWrite, EX_Mem2Reg, EX_RegDst,
        output EX_RSAddr, EX_RTAddr, EX_RDAddr, EX_BranchTaken,
        input  Stall, Flush_IFID, Flush_IDEX, FwdA_Sel, FwdB_Sel,
        input  StallCount, FlushCount
    );

    modport slave (
        input  ID_RSAddr, ID_RTAddr, ID_UsesRS, ID_UsesRT,
        input  EX_RegWrite, EX_Mem2Reg, EX_RegDst,
        input  EX_RSAddr, EX_RTAddr, EX_RDAddr, EX_BranchTaken,
        output Stall, Flush_IFID, Flush_IDEX, FwdA_Sel, FwdB_Sel,
        output StallCount, FlushCount
    );

endinterface

// File: rtl/hazard_forward_unit_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping, so a long run
// of events never reads back as a small number.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);
    import hazard_forward_unit_pkg::*;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: step on an event unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding controller for the 5-stage pipeline. Detects
// load-use hazards and taken branches, and chooses the EX operand sources
// from a private shadow of the EX/MEM and MEM/WB destination registers.
module hazard_forward_unit #(
    parameter int ADDR_W    = hazard_forward_unit_pkg::ADDR_W,
    parameter int CNT_W     = 16,
    parameter bit WB_FWD_EN = 1'b1
) (
    input logic                  CLOCK,
    input logic                  RESET,
    hazard_forward_unit_if.slave bus
);
    import hazard_forward_unit_pkg::*;

    // Destination of the instruction in EX and whether it really writes.
    logic [ADDR_W-1:0] ex_dest;
    logic              ex_wr;
    logic              lu_hit;

    // Shadow of the destinations further down the pipe.
    logic              mem_valid_q, mem_valid_d;
    logic [ADDR_W-1:0] mem_dest_q,  mem_dest_d;
    logic              mem_load_q,  mem_load_d;
    logic              wb_valid_q,  wb_valid_d;
    logic [ADDR_W-1:0] wb_dest_q,   wb_dest_d;

    logic              stall;
    logic              flush_ifid;
    logic              flush_idex;
    fwd_sel_t          fwd_a;
    fwd_sel_t          fwd_b;
    logic [CNT_W-1:0]  stall_count;
    logic [CNT_W-1:0]  flush_count;

    // Operand source for one EX read port. A load sitting in MEM never
    // yields the EX/MEM select: its data is not ready, and the load-use
    // stall keeps that case from reaching EX anyway.
    function automatic fwd_sel_t fwd_select(
        input logic [ADDR_W-1:0] src,
        input logic              m_valid,
        input logic              m_load,
        input logic [ADDR_W-1:0] m_dest,
        input logic              w_valid,
        input logic [ADDR_W-1:0] w_dest
    );
        fwd_sel_t sel;
        sel = FWD_REG;
        if (src == '0) begin
            sel = FWD_REG;
        end else if (m_valid && !m_load && (m_dest == src)) begin
            sel = FWD_EXMEM;
        end else if (WB_FWD_EN && w_valid && (w_dest == src)) begin
            sel = FWD_MEMWB;
        end
        return sel;
    endfunction

    // Resolve the EX destination and detect a load feeding the ID instruction.
    always_comb begin
        ex_dest = bus.EX_RegDst ? bus.EX_RDAddr : bus.EX_RTAddr;
        ex_wr   = bus.EX_RegWrite && (ex_dest != '0);
        lu_hit  = ex_wr && bus.EX_Mem2Reg &&
                  ((bus.ID_UsesRS && (bus.ID_RSAddr == ex_dest)) ||
                   (bus.ID_UsesRT && (bus.ID_RTAddr == ex_dest)));
    end

    // Shadow pipe advances every cycle; bubbles arrive with RegWrite low.
    always_comb begin
        mem_valid_d = ex_wr;
        mem_dest_d  = ex_dest;
        mem_load_d  = bus.EX_Mem2Reg;
        wb_valid_d  = mem_valid_q;
        wb_dest_d   = mem_dest_q;
    end

    // Shadow registers; reset drops any in-flight destinations.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            mem_valid_q <= 1'b0;
            mem_dest_q  <= '0;
            mem_load_q  <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_dest_q   <= '0;
        end else begin
            mem_valid_q <= mem_valid_d;
            mem_dest_q  <= mem_dest_d;
            mem_load_q  <= mem_load_d;
            wb_valid_q  <= wb_valid_d;
            wb_dest_q   <= wb_dest_d;
        end
    end

    // Pipeline control decisions. A taken branch squashes the ID
    // instruction, so it wins over a load-use stall. Everything is held
    // quiet while reset is asserted.
    always_comb begin
        stall      = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        fwd_a      = FWD_REG;
        fwd_b      = FWD_REG;
        if (!RESET) begin
            if (bus.EX_BranchTaken) begin
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
            end else if (lu_hit) begin
                stall      = 1'b1;
                flush_idex = 1'b1;
            end
            fwd_a = fwd_select(bus.EX_RSAddr, mem_valid_q, mem_load_q, mem_dest_q,
                               wb_valid_q, wb_dest_q);
            fwd_b = fwd_select(bus.EX_RTAddr, mem_valid_q, mem_load_q, mem_dest_q,
                               wb_valid_q, wb_dest_q);
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i   (CLOCK),
        .rst_i   (RESET),
        .inc_i   (stall),
        .count_o (stall_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i   (CLOCK),
        .rst_i   (RESET),
        .inc_i   (bus.EX_BranchTaken),
        .count_o (flush_count)
    );

    assign bus.Stall      = stall;
    assign bus.Flush_IFID = flush_ifid;
    assign bus.Flush_IDEX = flush_idex;
    assign bus.FwdA_Sel   = fwd_a;
    assign bus.FwdB_Sel   = fwd_b;
    assign bus.StallCount = stall_count;
    assign bus.FlushCount = flush_count;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit. u0 uses default parameters; u1
// sees the same stimulus with a 3-bit counter and WB forwarding disabled.
module tb_hazard_forward_unit;

    logic CLOCK = 1'b0;
    logic RESET = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 CLOCK = ~CLOCK;

    hazard_forward_unit_if #(.ADDR_W(5), .CNT_W(16)) bus0 ();
    hazard_forward_unit_if #(.ADDR_W(5), .CNT_W(3))  bus1 ();

    hazard_forward_unit #(.ADDR_W(5), .CNT_W(16), .WB_FWD_EN(1'b1)) u0 (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus0)
    );

    hazard_forward_unit #(.ADDR_W(5), .CNT_W(3), .WB_FWD_EN(1'b0)) u1 (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus1)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply one cycle of EX/ID inputs to both controllers.
    task automatic drive(input logic rw, input logic m2r, input logic rdst,
                         input logic [4:0] ers, input logic [4:0] ert, input logic [4:0] erd,
                         input logic br,
                         input logic [4:0] irs, input logic [4:0] irt,
                         input logic urs, input logic urt);
        bus0.EX_RegWrite = rw;   bus1.EX_RegWrite = rw;
        bus0.EX_Mem2Reg  = m2r;  bus1.EX_Mem2Reg  = m2r;
        bus0.EX_RegDst   = rdst; bus1.EX_RegDst   = rdst;
        bus0.EX_RSAddr   = ers;  bus1.EX_RSAddr   = ers;
        bus0.EX_RTAddr   = ert;  bus1.EX_RTAddr   = ert;
        bus0.EX_RDAddr   = erd;  bus1.EX_RDAddr   = erd;
        bus0.EX_BranchTaken = br; bus1.EX_BranchTaken = br;
        bus0.ID_RSAddr   = irs;  bus1.ID_RSAddr   = irs;
        bus0.ID_RTAddr   = irt;  bus1.ID_RTAddr   = irt;
        bus0.ID_UsesRS   = urs;  bus1.ID_UsesRS   = urs;
        bus0.ID_UsesRT   = urt;  bus1.ID_UsesRT   = urt;
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    initial begin
        // Reset asserted with a load-use pattern on the inputs: outputs stay quiet.
        drive(1, 1, 0, 0, 5, 0, 0, 0, 5, 0, 1);
        #2;
        check_val("rst_stall",      int'(bus0.Stall), 0);
        check_val("rst_flush_idex", int'(bus0.Flush_IDEX), 0);
        check_val("rst_stallcnt",   int'(bus0.StallCount), 0);
        check_val("rst_flushcnt",   int'(bus0.FlushCount), 0);
        @(posedge CLOCK);
        @(posedge CLOCK);
        #5;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        RESET = 1'b0;
        #1;
        check_val("post_rst_fwda", int'(bus0.FwdA_Sel), 0);

        // Back-to-back ALU: add $3 then consumer of $3.
        tick(); drive(1, 0, 1, 0, 0, 3, 0, 0, 0, 0, 0); #1;
        check_val("alu_prod_fwda", int'(bus0.FwdA_Sel), 0);
        tick(); drive(0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0); #1;
        check_val("alu_exmem_fwda",    int'(bus0.FwdA_Sel), 1);
        check_val("alu_exmem_fwda_u1", int'(bus1.FwdA_Sel), 1);
        tick(); drive(0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0); #1;
        check_val("alu_memwb_fwda",    int'(bus0.FwdA_Sel), 2);
        check_val("alu_memwb_fwdb",    int'(bus0.FwdB_Sel), 0);
        check_val("nowbfwd_fwda_u1",   int'(bus1.FwdA_Sel), 0);

        // MEM and WB both hold $7: MEM wins.
        tick(); drive(1, 0, 1, 0, 0, 7, 0, 0, 0, 0, 0);
        tick(); drive(1, 0, 1, 0, 0, 7, 0, 0, 0, 0, 0);
        tick(); drive(0, 0, 0, 7, 7, 0, 0, 0, 0, 0, 0); #1;
        check_val("prio_fwda",    int'(bus0.FwdA_Sel), 1);
        check_val("prio_fwdb",    int'(bus0.FwdB_Sel), 1);
        check_val("prio_fwda_u1", int'(bus1.FwdA_Sel), 1);
        tick(); drive(0, 0, 0, 7, 7, 0, 0, 0, 0, 0, 0); #1;
        check_val("wbonly_fwda",    int'(bus0.FwdA_Sel), 2);
        check_val("wbonly_fwda_u1", int'(bus1.FwdA_Sel), 0);

        // Load-use: lw $5 in EX, ID reads $5 through rt.
        tick(); drive(1, 1, 0, 0, 5, 0, 0, 0, 5, 0, 1); #1;
        check_val("lu_stall",      int'(bus0.Stall), 1);
        check_val("lu_flush_idex", int'(bus0.Flush_IDEX), 1);
        check_val("lu_flush_ifid", int'(bus0.Flush_IFID), 0);
        check_val("lu_cnt_before", int'(bus0.StallCount), 0);
        // Bubble in EX (rt field still 5); load now in MEM must not forward.
        tick(); drive(0, 0, 0, 0, 5, 0, 0, 0, 5, 0, 1); #1;
        check_val("lu_release",    int'(bus0.Stall), 0);
        check_val("lu_bubble_idex", int'(bus0.Flush_IDEX), 0);
        check_val("lu_stallcnt",   int'(bus0.StallCount), 1);
        check_val("lu_memload_fwdb", int'(bus0.FwdB_Sel), 0);
        // Dependent instruction reaches EX with the load in WB.
        tick(); drive(1, 0, 1, 0, 5, 6, 0, 0, 0, 0, 0); #1;
        check_val("lu_wb_fwdb",    int'(bus0.FwdB_Sel), 2);
        check_val("lu_wb_fwdb_u1", int'(bus1.FwdB_Sel), 0);
        check_val("lu_dep_stall",  int'(bus0.Stall), 0);

        // Writes to $0 never create hazards or forwarding.
        tick(); drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1); #1;
        check_val("r0_no_lu",   int'(bus0.Stall), 0);
        check_val("r0_no_idex", int'(bus0.Flush_IDEX), 0);
        tick(); drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        check_val("r0_fwda_1", int'(bus0.FwdA_Sel), 0);
        check_val("r0_fwdb_1", int'(bus0.FwdB_Sel), 0);
        tick(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        check_val("r0_fwda_2", int'(bus0.FwdA_Sel), 0);

        // Branch taken in the same cycle as a load-use hazard.
        tick(); drive(1, 1, 0, 0, 9, 0, 1, 9, 0, 1, 0); #1;
        check_val("br_flush_ifid", int'(bus0.Flush_IFID), 1);
        check_val("br_flush_idex", int'(bus0.Flush_IDEX), 1);
        check_val("br_stall",      int'(bus0.Stall), 0);
        check_val("br_cnt_before", int'(bus0.FlushCount), 0);
        // ALU write to $5 via rt, sets up a forward for the reset test.
        tick(); drive(1, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0); #1;
        check_val("br_flushcnt",   int'(bus0.FlushCount), 1);
        check_val("br_stallcnt",   int'(bus0.StallCount), 1);
        check_val("br_ifid_clear", int'(bus0.Flush_IFID), 0);

        // Reset pulse in the middle of a stall cycle.
        tick(); drive(1, 1, 0, 0, 5, 0, 0, 0, 5, 0, 1); #1;
        check_val("pre_rst_stall", int'(bus0.Stall), 1);
        check_val("pre_rst_fwdb",  int'(bus0.FwdB_Sel), 1);
        #2;
        RESET = 1'b1;
        #1;
        check_val("mid_rst_stall",      int'(bus0.Stall), 0);
        check_val("mid_rst_flush_idex", int'(bus0.Flush_IDEX), 0);
        check_val("mid_rst_flush_ifid", int'(bus0.Flush_IFID), 0);
        check_val("mid_rst_fwdb",       int'(bus0.FwdB_Sel), 0);
        check_val("mid_rst_stallcnt",   int'(bus0.StallCount), 0);
        check_val("mid_rst_flushcnt",   int'(bus0.FlushCount), 0);
        @(posedge CLOCK);
        #3;
        RESET = 1'b0;
        #1;
        check_val("rel_stall",    int'(bus0.Stall), 1);
        check_val("rel_fwdb",     int'(bus0.FwdB_Sel), 0);
        check_val("rel_stallcnt", int'(bus0.StallCount), 0);

        // Hold the stall to drive the narrow counter into saturation.
        for (int i = 0; i < 9; i++) begin
            tick();
        end
        check_val("sat_u0_cnt", int'(bus0.StallCount), 9);
        check_val("sat_u1_cnt", int'(bus1.StallCount), 7);
        tick();
        check_val("sat_u0_cnt2", int'(bus0.StallCount), 10);
        check_val("sat_u1_hold", int'(bus1.StallCount), 7);

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
